// File: rtl/mem_banked_if.sv
// rtl/mem_banked_if.sv - request/response bundle for mem_banked
// Purpose: groups the per-port valid/ready request channel and the
//   fixed-latency response channel of mem_banked into one interface.
// Signals (NPORTS ports, flattened, port p in slice p):
//   req_valid/req_ready  [NPORTS]    request handshake
//   req_wstrb            [4*NPORTS]  byte enables, all zero = read
//   req_addr/req_wdata   [32*NPORTS] byte address / write data
//   rsp_valid/rsp_err    [NPORTS]    response pulse / out-of-range flag
//   rsp_rdata            [32*NPORTS] read data (0 for writes)
// Modports: master (requester side), slave (memory side).
interface mem_banked_if #(
  parameter int NPORTS = 2
);
  logic [NPORTS-1:0]    req_valid;
  logic [NPORTS-1:0]    req_ready;
  logic [4*NPORTS-1:0]  req_wstrb;
  logic [32*NPORTS-1:0] req_addr;
  logic [32*NPORTS-1:0] req_wdata;
  logic [NPORTS-1:0]    rsp_valid;
  logic [32*NPORTS-1:0] rsp_rdata;
  logic [NPORTS-1:0]    rsp_err;

  modport master (
    output req_valid, req_wstrb, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wstrb, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_banked.sv
// rtl/mem_banked.sv - bank-interleaved, byte-writable multi-port memory
// Purpose: NPORTS request ports share BANKS single-port banks using
//   low-order word interleaving. Ports hitting distinct banks proceed in
//   parallel; collisions on a bank are granted round-robin. Every accepted
//   request gets exactly one response READ_LATENCY (1 or 2) cycles later.
// Ports:
//   i_clk    - clock, all state updates on the rising edge
//   i_reset  - synchronous active-high reset (memory contents preserved)
//   bus      - mem_banked_if.slave request/response channel
// Option macro: MEM_BOUNDS_EN - flag out-of-range addresses with rsp_err,
//   drop their writes and return zero for their reads; when undefined the
//   upper address bits are ignored and rsp_err stays 0.
module mem_banked #(
  parameter int    NPORTS       = 2,
  parameter int    BANKS        = 4,
  parameter int    DEPTH        = 2048,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input logic         i_clk,
  input logic         i_reset,
  mem_banked_if.slave bus
);
  localparam int AW   = $clog2(DEPTH);
  localparam int ROWS = DEPTH / BANKS;
  localparam int BW   = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PW   = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  // Per-port address decode
  logic [BW-1:0]     w_bank [NPORTS];
  logic [RW-1:0]     w_row  [NPORTS];
  logic [NPORTS-1:0] w_oor;
  logic [NPORTS-1:0] w_wr;
  logic              w_unused;

  always_comb begin
    w_unused = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      w_bank[p] = BW'(bus.req_addr[32*p+2 +: AW] % BANKS);
      w_row[p]  = RW'(bus.req_addr[32*p+2 +: AW] / BANKS);
      w_wr[p]   = |bus.req_wstrb[4*p +: 4];
`ifdef MEM_BOUNDS_EN
      w_oor[p]  = |bus.req_addr[32*p+AW+2 +: 30-AW];
`else
      w_oor[p]  = 1'b0;
`endif
      w_unused  = w_unused ^ (^bus.req_addr[32*p +: 2]) ^ (^bus.req_addr[32*p+AW+2 +: 30-AW]);
    end
  end

  // Round-robin arbitration per bank
  logic [NPORTS-1:0] w_hit [BANKS];
  logic [BANKS-1:0]  w_go;
  logic [PW-1:0]     w_gnt [BANKS];
  logic [NPORTS-1:0] w_ready;
  logic [PW-1:0]     r_rr;
  logic [PW-1:0]     w_rr_nxt;
  logic              w_rr_upd;

  always_comb begin
    w_go     = '0;
    w_ready  = '0;
    w_rr_upd = 1'b0;
    w_rr_nxt = r_rr;
    for (int b = 0; b < BANKS; b++) begin
      int n_hit;
      n_hit    = 0;
      w_hit[b] = '0;
      w_gnt[b] = '0;
      for (int p = 0; p < NPORTS; p++) begin
        if (bus.req_valid[p] && (w_bank[p] == BW'(b))) begin
          w_hit[b][p] = 1'b1;
          n_hit       = n_hit + 1;
        end
      end
      // First requester at or after the pointer, scanning cyclically
      for (int k = 0; k < NPORTS; k++) begin
        int idx;
        idx = int'(r_rr) + k;
        if (idx >= NPORTS) idx = idx - NPORTS;
        if (!w_go[b] && w_hit[b][idx]) begin
          w_go[b]  = 1'b1;
          w_gnt[b] = PW'(idx);
        end
      end
      if (w_go[b] && !i_reset) w_ready[w_gnt[b]] = 1'b1;
      // Only the lowest-indexed contended bank moves the shared pointer
      if ((n_hit >= 2) && !w_rr_upd) begin
        w_rr_upd = 1'b1;
        w_rr_nxt = (int'(w_gnt[b]) == NPORTS - 1) ? '0 : w_gnt[b] + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)       r_rr <= '0;
    else if (w_rr_upd) r_rr <= w_rr_nxt;
  end

  // Bank-side request mux
  logic [RW-1:0]    w_b_row   [BANKS];
  logic [3:0]       w_b_strb  [BANKS];
  logic [31:0]      w_b_wdata [BANKS];
  logic [BANKS-1:0] w_b_rd;

  always_comb begin
    w_b_rd = '0;
    for (int b = 0; b < BANKS; b++) begin
      int p;
      p            = int'(w_gnt[b]);
      w_b_row[b]   = w_row[p];
      w_b_wdata[b] = bus.req_wdata[32*p +: 32];
      w_b_strb[b]  = '0;
      if (w_go[b] && !i_reset) begin
        if (!w_oor[p]) w_b_strb[b] = bus.req_wstrb[4*p +: 4];
        w_b_rd[b] = !w_wr[p];
      end
    end
  end

  // Storage: no reset, contents survive i_reset
  logic [31:0] r_mem    [BANKS][ROWS];
  logic [31:0] r_bank_q [BANKS];

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < BANKS; b++) begin
      for (int i = 0; i < 4; i++) begin
        if (w_b_strb[b][i]) r_mem[b][w_b_row[b]][8*i +: 8] <= w_b_wdata[b][8*i +: 8];
      end
      if (w_b_rd[b]) r_bank_q[b] <= r_mem[b][w_b_row[b]];
    end
  end

  // Response stage 1: remembers which bank holds each port's read word
  logic [NPORTS-1:0] r_v1;
  logic [NPORTS-1:0] r_zero1;
  logic [NPORTS-1:0] r_err1;
  logic [BW-1:0]     r_bank1 [NPORTS];
  logic [31:0]       w_d1    [NPORTS];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_v1    <= '0;
      r_zero1 <= '0;
      r_err1  <= '0;
    end else begin
      r_v1 <= w_ready;
      for (int p = 0; p < NPORTS; p++) begin
        if (w_ready[p]) begin
          r_bank1[p] <= w_bank[p];
          r_zero1[p] <= w_wr[p] | w_oor[p];
          r_err1[p]  <= w_oor[p];
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NPORTS; p++) w_d1[p] = r_zero1[p] ? 32'h0 : r_bank_q[r_bank1[p]];
  end

  logic [NPORTS-1:0] w_v;
  logic [NPORTS-1:0] w_e;
  logic [31:0]       w_d [NPORTS];

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [NPORTS-1:0] r_v2;
      logic [NPORTS-1:0] r_err2;
      logic [31:0]       r_d2 [NPORTS];
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          r_v2   <= '0;
          r_err2 <= '0;
          for (int p = 0; p < NPORTS; p++) r_d2[p] <= '0;
        end else begin
          r_v2   <= r_v1;
          r_err2 <= r_err1;
          for (int p = 0; p < NPORTS; p++) r_d2[p] <= w_d1[p];
        end
      end
      always_comb begin
        w_v = r_v2;
        w_e = r_err2;
        for (int p = 0; p < NPORTS; p++) w_d[p] = r_d2[p];
      end
    end else begin : g_lat1
      always_comb begin
        w_v = r_v1;
        w_e = r_err1;
        for (int p = 0; p < NPORTS; p++) w_d[p] = w_d1[p];
      end
    end
  endgenerate

  // Outputs are masked by i_reset so a response in flight when reset
  // rises is never seen.
  always_comb begin
    bus.req_ready = w_ready;
    bus.rsp_valid = '0;
    bus.rsp_rdata = '0;
    bus.rsp_err   = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (w_v[p] && !i_reset) begin
        bus.rsp_valid[p]          = 1'b1;
        bus.rsp_rdata[32*p +: 32] = w_d[p];
        bus.rsp_err[p]            = w_e[p];
      end
    end
  end
endmodule

// File: tb/tb_mem_banked.sv
// tb/tb_mem_banked.sv - scoreboard bench for mem_banked at read latency 1 and 2
module tb_mem_banked;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

`ifdef MEM_BOUNDS_EN
  localparam bit BND = 1'b1;
`else
  localparam bit BND = 1'b0;
`endif

  mem_banked_if #(.NPORTS(2)) ifa ();
  mem_banked_if #(.NPORTS(2)) ifb ();

  assign ifb.req_valid = ifa.req_valid;
  assign ifb.req_wstrb = ifa.req_wstrb;
  assign ifb.req_addr  = ifa.req_addr;
  assign ifb.req_wdata = ifa.req_wdata;

  mem_banked #(.NPORTS(2), .BANKS(4), .DEPTH(2048), .READ_LATENCY(1), .INIT_FILE(""))
    dut_a (.i_clk(clk), .i_reset(reset), .bus(ifa.slave));
  mem_banked #(.NPORTS(2), .BANKS(4), .DEPTH(2048), .READ_LATENCY(2), .INIT_FILE(""))
    dut_b (.i_clk(clk), .i_reset(reset), .bus(ifb.slave));

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          cyc;
  } exp_t;

  exp_t q [2][2][$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  logic [1:0]  mv [2];
  logic [1:0]  me [2];
  logic [31:0] md [2][2];
  always_comb begin
    mv[0] = ifa.rsp_valid;  mv[1] = ifb.rsp_valid;
    me[0] = ifa.rsp_err;    me[1] = ifb.rsp_err;
    md[0][0] = ifa.rsp_rdata[31:0];  md[0][1] = ifa.rsp_rdata[63:32];
    md[1][0] = ifb.rsp_rdata[31:0];  md[1][1] = ifb.rsp_rdata[63:32];
  end

  // Monitor: pops one expectation per response pulse
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      for (int p = 0; p < 2; p++) begin
        if (mv[u][p] === 1'b1) begin
          if (q[u][p].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_unexpected d%0d p%0d: got rsp_valid=1 required none", u, p);
          end else begin
            mon_e = q[u][p].pop_front();
            check($sformatf("rdata d%0d p%0d", u, p), md[u][p], mon_e.d);
            check($sformatf("err d%0d p%0d", u, p), {31'b0, me[u][p]}, {31'b0, mon_e.e});
            check($sformatf("cycle d%0d p%0d", u, p), cyc, mon_e.cyc);
          end
        end
      end
    end
  end

  // One request cycle on both ports; pushes expectations for accepted ports
  task automatic step(input string name, input logic [1:0] v,
                      input logic [31:0] a0, input logic [3:0] s0, input logic [31:0] d0,
                      input logic [31:0] e0, input logic x0,
                      input logic [31:0] a1, input logic [3:0] s1, input logic [31:0] d1,
                      input logic [31:0] e1, input logic x1,
                      input logic [1:0] exp_rdy);
    logic [1:0] ra, rb;
    ifa.req_valid = v;
    ifa.req_addr  = {a1, a0};
    ifa.req_wstrb = {s1, s0};
    ifa.req_wdata = {d1, d0};
    @(negedge clk);
    ra = ifa.req_ready;
    rb = ifb.req_ready;
    check({name, " ready d0"}, {30'b0, ra}, {30'b0, exp_rdy});
    check({name, " ready d1"}, {30'b0, rb}, {30'b0, exp_rdy});
    if (ra[0]) q[0][0].push_back('{d: e0, e: x0, cyc: cyc + 1});
    if (ra[1]) q[0][1].push_back('{d: e1, e: x1, cyc: cyc + 1});
    if (rb[0]) q[1][0].push_back('{d: e0, e: x0, cyc: cyc + 2});
    if (rb[1]) q[1][1].push_back('{d: e1, e: x1, cyc: cyc + 2});
    @(posedge clk);
    #1;
    ifa.req_valid = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    ifa.req_valid = 2'b11;
    ifa.req_addr  = '0;
    ifa.req_wstrb = '0;
    ifa.req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset ready d0", {30'b0, ifa.req_ready}, 32'h0);
    check("reset ready d1", {30'b0, ifb.req_ready}, 32'h0);
    check("reset rsp_valid d0", {30'b0, ifa.rsp_valid}, 32'h0);
    check("reset rsp_valid d1", {30'b0, ifb.rsp_valid}, 32'h0);
    check("reset rdata d0", ifa.rsp_rdata[31:0] | ifa.rsp_rdata[63:32], 32'h0);
    check("reset rdata d1", ifb.rsp_rdata[31:0] | ifb.rsp_rdata[63:32], 32'h0);
    check("reset err d0", {30'b0, ifa.rsp_err}, 32'h0);
    check("reset err d1", {30'b0, ifb.rsp_err}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    ifa.req_valid = '0;

    // Full write, read-after-write, byte strobe
    step("wr_dead", 2'b01, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 0, 0, 0, 0, 0, 2'b01);
    step("rd_dead", 2'b01, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, 0, 0, 0, 0, 0, 2'b01);
    step("wr_byte", 2'b01, 32'h10, 4'b0100, 32'h00AA0000, 32'h0, 1'b0, 0, 0, 0, 0, 0, 2'b01);
    step("rd_byte", 2'b01, 32'h10, 4'h0, 32'h0, 32'hDEAABEEF, 1'b0, 0, 0, 0, 0, 0, 2'b01);

    // Parallel ports on banks 0 and 1
    step("wr_par", 2'b11, 32'h00, 4'hF, 32'h11111111, 32'h0, 1'b0,
         32'h04, 4'hF, 32'h22222222, 32'h0, 1'b0, 2'b11);
    step("rd_par", 2'b11, 32'h00, 4'h0, 32'h0, 32'h11111111, 1'b0,
         32'h04, 4'h0, 32'h0, 32'h22222222, 1'b0, 2'b11);
    idle(3);

    // Conflict on bank 0 starting from a fresh pointer
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step($sformatf("conflict%0d", i), 2'b11, 32'h00, 4'h0, 32'h0, 32'h11111111, 1'b0,
           32'h10, 4'h0, 32'h0, 32'hDEAABEEF, 1'b0, (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    idle(3);

    // Reset while a read is in flight
    step("rd_flight", 2'b01, 32'h10, 4'h0, 32'h0, 32'hDEAABEEF, 1'b0, 0, 0, 0, 0, 0, 2'b01);
    reset = 1'b1;
    for (int u = 0; u < 2; u++) for (int p = 0; p < 2; p++) q[u][p].delete();
    @(negedge clk);
    check("flush1 rsp_valid d0", {30'b0, ifa.rsp_valid}, 32'h0);
    check("flush1 rsp_valid d1", {30'b0, ifb.rsp_valid}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("flush2 rsp_valid d0", {30'b0, ifa.rsp_valid}, 32'h0);
    check("flush2 rsp_valid d1", {30'b0, ifb.rsp_valid}, 32'h0);
    @(posedge clk);
    #1;
    step("rd_after_rst0", 2'b01, 32'h10, 4'h0, 32'h0, 32'hDEAABEEF, 1'b0, 0, 0, 0, 0, 0, 2'b01);
    step("rd_after_rst1", 2'b10, 0, 0, 0, 0, 0, 32'h04, 4'h0, 32'h0, 32'h22222222, 1'b0, 2'b10);

    // Address beyond DEPTH*4 bytes
    step("wr_oor", 2'b01, 32'h2000, 4'hF, 32'h55555555, 32'h0, BND, 0, 0, 0, 0, 0, 2'b01);
    step("rd_oor", 2'b01, 32'h2000, 4'h0, 32'h0, BND ? 32'h0 : 32'h55555555, BND,
         0, 0, 0, 0, 0, 2'b01);
    step("rd_word0", 2'b10, 0, 0, 0, 0, 0,
         32'h0000, 4'h0, 32'h0, BND ? 32'h11111111 : 32'h55555555, 1'b0, 2'b10);

    idle(4);
    for (int u = 0; u < 2; u++) begin
      for (int p = 0; p < 2; p++) begin
        check($sformatf("drain d%0d p%0d", u, p), q[u][p].size(), 32'h0);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
